// File: rtl/button_event_if.sv
// Event handshake between the button arbiter and the command logic.
//   o_valid  event offered (driven by the arbiter)
//   o_id     channel index of the offered event
//   i_ready  consumer accepts; transfer when o_valid & i_ready at posedge
// master = event producer (arbiter), slave = event consumer.
interface button_event_if #(
    parameter int ID_W = 2
);
    logic            o_valid;
    logic [ID_W-1:0] o_id;
    logic            i_ready;

    modport master (output o_valid, output o_id, input i_ready);
    modport slave  (input o_valid, input o_id, output i_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// button_event_arbiter
// Turns N_CH asynchronous level inputs into a single stream of "channel k pressed"
// events. Each channel is synchronised (2 FFs), debounced, edge detected and held
// in a sticky pending bit; a round-robin arbiter serialises pending events onto
// a valid/ready handshake.
// Ports:
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset
//   i_level         raw level inputs, asynchronous to i_clk
//   evt             event handshake (master side: o_valid, o_id out; i_ready in)
//   o_pending       pending-event register (excludes the event currently on o_id)
//   o_overflow      sticky flag: an edge arrived while its pending bit was already set
//   i_clr_overflow  synchronous clear of o_overflow (a new overflow wins)
module button_event_arbiter #(
    parameter int N_CH       = 4,
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 3,
    parameter int ID_W       = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [N_CH-1:0]     i_level,
    button_event_if.master      evt,
    output logic [N_CH-1:0]     o_pending,
    output logic                o_overflow,
    input  logic                i_clr_overflow
);

    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    // Round-robin pick: first set bit of req searching ptr, ptr+1, .. with wrap.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                                input logic [ID_W-1:0] ptr);
        logic [N_CH-1:0] rot;
        int              off;
        int              sum;
        rot = N_CH'({req, req} >> ptr);
        off = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        sum = int'(ptr) + off;
        if (sum >= N_CH) sum = sum - N_CH;
        return ID_W'(sum);
    endfunction

    logic [N_CH-1:0]  sync_p0, sync_p1;
    logic [N_CH-1:0]  filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  rise;

    logic [N_CH-1:0]  pending_q, pending_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    state_t           state_q, state_d;

    logic [N_CH-1:0]  req;
    logic [ID_W-1:0]  pick;
    logic             grant_en;
    logic [N_CH-1:0]  grant_mask;

    // ---- stage: two-flop synchroniser ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= i_level;
            sync_p1 <= sync_p0;
        end
    end

    // ---- stage: debounce filter and rising-edge detect ----
    always_comb begin
        filt_d = filt_q;
        for (int k = 0; k < N_CH; k++) begin
            cnt_d[k] = '0;
            if (sync_p1[k] != filt_q[k]) begin
                if (cnt_q[k] == CNT_W'(DEB_CYCLES - 1)) filt_d[k] = sync_p1[k];
                else                                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    // Rise is taken from the filter's next value so that the pending bit is set
    // on the same edge the filtered state goes high.
    assign rise = filt_d & ~filt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            filt_q <= '0;
            for (int k = 0; k < N_CH; k++) cnt_q[k] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int k = 0; k < N_CH; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    // ---- stage: pending register and round-robin arbiter ----
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        ptr_d   = ptr_q;

        // While offering, a transfer may hand over an event that rises on this
        // very edge; from IDLE only already-registered events are eligible.
        req      = (state_q == OFFER) ? (pending_q | rise) : pending_q;
        pick     = rr_pick(req, ptr_q);
        grant_en = (|req) && ((state_q == IDLE) || evt.i_ready);
        grant_mask = grant_en ? (N_CH'(1) << pick) : '0;

        // A granted bit is consumed unless a fresh edge lands on it in the
        // same cycle while an older event was also pending; then one remains.
        pending_d = (pending_q | rise) & ~(grant_mask & ~(pending_q & rise));

        if (|(rise & pending_q & ~grant_mask)) ovf_d = 1'b1;
        else if (i_clr_overflow)               ovf_d = 1'b0;
        else                                   ovf_d = ovf_q;

        if (grant_en) begin
            state_d = OFFER;
            valid_d = 1'b1;
            id_d    = pick;
            ptr_d   = (pick == ID_W'(N_CH - 1)) ? '0 : pick + ID_W'(1);
        end else if (state_q == OFFER && evt.i_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
        end
    end

    assign evt.o_valid = valid_q;
    assign evt.o_id    = id_q;
    assign o_pending   = pending_q;
    assign o_overflow  = ovf_q;

endmodule
